// File: rtl/iigs_io_ctrl_if.sv
// CPU-side bus for the $C0xx IO controller: request from the 65C816 core,
// decode/read-data/ready back from the controller.
interface iigs_io_ctrl_if;
    logic        cen;
    logic [7:0]  bank;
    logic [15:0] addr;
    logic        valid;
    logic        cpu_rw;
    logic [7:0]  cpu_dout;
    logic        io_sel;
    logic [7:0]  io_dout;
    logic        rdy;

    modport master (
        output cen, bank, addr, valid, cpu_rw, cpu_dout,
        input  io_sel, io_dout, rdy
    );

    modport slave (
        input  cen, bank, addr, valid, cpu_rw, cpu_dout,
        output io_sel, io_dout, rdy
    );
endinterface

// File: rtl/iigs_io_ctrl.sv
// $C0xx soft-switch / IO controller: internal switch registers plus a
// strobe/ack bridge to peripheral channels that stalls the CPU through rdy.
module iigs_io_ctrl #(
    parameter int                        NUM_PERIPH  = 2,
    parameter logic [NUM_PERIPH*256-1:0] PERIPH_MASK = {
        (256'd1 << 8'h33),
        ((256'd1 << 8'h00) | (256'd1 << 8'h10) | (256'd1 << 8'h24) |
         (256'd1 << 8'h25) | (256'd1 << 8'h26) | (256'd1 << 8'h27))
    },
    parameter logic [255:0]              REG_MASK    =
        (256'd1 << 8'h22) | (256'd1 << 8'h2D) | (256'd1 << 8'h34) |
        (256'd1 << 8'h35) | (256'd1 << 8'h36) | (256'd1 << 8'h68),
    parameter int                        TIMEOUT     = 15
) (
    input  logic                       clk_sys,
    input  logic                       reset,
    iigs_io_ctrl_if.slave              bus,
    output logic                       timeout,
    output logic [NUM_PERIPH-1:0]      per_strobe,
    output logic [7:0]                 per_addr,
    output logic [7:0]                 per_din,
    output logic                       per_rw,
    input  logic [NUM_PERIPH-1:0]      per_ack,
    input  logic [NUM_PERIPH*8-1:0]    per_dout,
    output logic [7:0]                 shadow,
    output logic [7:0]                 textcolor,
    output logic [3:0]                 bordercolor,
    output logic [7:0]                 sltromsel
);
    localparam logic [255:0] FIXED_REGS =
        (256'd1 << 8'h22) | (256'd1 << 8'h2D) | (256'd1 << 8'h34) |
        (256'd1 << 8'h35) | (256'd1 << 8'h36) | (256'd1 << 8'h68);
    localparam logic [255:0] REG_ALL = REG_MASK | FIXED_REGS;
    localparam int           CH_W    = (NUM_PERIPH > 1) ? $clog2(NUM_PERIPH) : 1;

    typedef enum logic [1:0] {S_IDLE, S_STROBE, S_WAIT, S_DONE} state_t;

    state_t          state, state_nx;
    logic [7:0]      regs [256];
    logic [CH_W-1:0] ch_q, hit_ch;
    logic [7:0]      cnt;
    logic [7:0]      off;
    logic            win, p_any, phit, rhit;
    logic            accept, reg_acc, ack_sel, expired, ff_write;

    function automatic logic [7:0] reg_init(input logic [7:0] o);
        case (o)
            8'h35:   reg_init = 8'h08;
            8'h36:   reg_init = 8'h80;
            8'h68:   reg_init = 8'h09;
            default: reg_init = 8'h00;
        endcase
    endfunction

    assign off  = bus.addr[7:0];
    assign win  = (bus.addr[15:8] == 8'hC0) &&
                  (bus.bank inside {8'h00, 8'h01, 8'hE0, 8'hE1}) && !regs[8'h35][6];

    // Descending scan so the lowest-numbered owning channel wins.
    always_comb begin
        p_any  = 1'b0;
        hit_ch = '0;
        for (int i = NUM_PERIPH - 1; i >= 0; i--) begin
            if (PERIPH_MASK[i*256 + int'(off)]) begin
                p_any  = 1'b1;
                hit_ch = CH_W'(i);
            end
        end
    end

    assign phit       = win && p_any && !FIXED_REGS[off];
    assign rhit       = win && REG_ALL[off] && !phit;
    assign bus.io_sel = bus.valid && (phit || rhit);

    assign accept   = (state == S_IDLE) && bus.cen && bus.valid && phit;
    assign reg_acc  = (state == S_IDLE) && bus.cen && bus.valid && rhit;
    assign ff_write = (state == S_IDLE) && bus.cen && bus.valid && win &&
                      (off == 8'hFF) && !bus.cpu_rw;
    assign ack_sel  = per_ack[ch_q];
    assign expired  = (cnt == 8'(TIMEOUT - 1));

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) state <= S_IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:   if (accept) state_nx = S_STROBE;
            S_STROBE: state_nx = S_WAIT;
            S_WAIT:   if (ack_sel || expired) state_nx = S_DONE;
            S_DONE:   if (bus.cen) state_nx = S_IDLE;
            default:  state_nx = S_IDLE;
        endcase
    end

    // rdy falls combinationally in IDLE so the CPU never sees a peripheral cycle complete early.
    always_comb begin
        per_strobe = '0;
        if (state == S_STROBE) per_strobe[ch_q] = 1'b1;
        bus.rdy = (state == S_DONE) || ((state == S_IDLE) && !(bus.valid && phit));
    end

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 256; i++) regs[i] <= reg_init(8'(i));
            bus.io_dout <= 8'h00;
            per_addr    <= 8'h00;
            per_din     <= 8'h00;
            per_rw      <= 1'b1;
            ch_q        <= '0;
            cnt         <= 8'h00;
            timeout     <= 1'b0;
        end else begin
            if (reg_acc) begin
                if (bus.cpu_rw) bus.io_dout <= regs[off];
                else            regs[off]   <= (off == 8'h68) ? (bus.cpu_dout | 8'h01) : bus.cpu_dout;
            end
            if (ff_write) timeout <= 1'b0;
            case (state)
                S_IDLE: if (accept) begin
                    per_addr <= off;
                    per_din  <= bus.cpu_dout;
                    per_rw   <= bus.cpu_rw;
                    ch_q     <= hit_ch;
                end
                S_STROBE: cnt <= 8'h00;
                S_WAIT: begin
                    if (ack_sel) begin
                        if (per_rw) bus.io_dout <= per_dout[int'(ch_q)*8 +: 8];
                    end else if (expired) begin
                        if (per_rw) bus.io_dout <= 8'hFF;
                        timeout <= 1'b1;
                    end else begin
                        cnt <= cnt + 8'h01;
                    end
                end
                default: ;
            endcase
        end
    end

    assign shadow      = regs[8'h35];
    assign textcolor   = regs[8'h22];
    assign bordercolor = regs[8'h34][3:0];
    assign sltromsel   = regs[8'h2D];
endmodule

// File: tb/tb_iigs_io_ctrl.sv
// Directed bench for iigs_io_ctrl: read data and peripheral strobes are
// checked by monitors against queues filled by the stimulus thread.
module tb_iigs_io_ctrl;
    logic        clk_sys = 1'b0;
    logic        reset;
    logic        timeout;
    logic [1:0]  per_strobe;
    logic [7:0]  per_addr, per_din;
    logic        per_rw;
    logic [1:0]  per_ack;
    logic [15:0] per_dout;
    logic [7:0]  shadow, textcolor, sltromsel;
    logic [3:0]  bordercolor;

    always #5 clk_sys = ~clk_sys;

    iigs_io_ctrl_if bus ();

    iigs_io_ctrl dut (
        .clk_sys     (clk_sys),
        .reset       (reset),
        .bus         (bus),
        .timeout     (timeout),
        .per_strobe  (per_strobe),
        .per_addr    (per_addr),
        .per_din     (per_din),
        .per_rw      (per_rw),
        .per_ack     (per_ack),
        .per_dout    (per_dout),
        .shadow      (shadow),
        .textcolor   (textcolor),
        .bordercolor (bordercolor),
        .sltromsel   (sltromsel)
    );

    typedef struct {
        string      name;
        logic [7:0] val;
    } rd_exp_t;

    typedef struct {
        string      name;
        int         ch;
        logic [7:0] addr;
        logic       rw;
        logic [7:0] din;
    } st_exp_t;

    rd_exp_t    rd_q[$];
    st_exp_t    st_q[$];
    rd_exp_t    rd_e;
    st_exp_t    st_e;
    int         n_vec = 0;
    int         n_bad = 0;
    int         ack_dly = -1;
    logic [7:0] ack_data = 8'h00;
    logic       stray = 1'b0;
    int         low;
    logic       sel;

    task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %02h, expected %02h", name, act, exp);
        end
    endtask

    task automatic push_rd(input string name, input logic [7:0] v);
        rd_exp_t e;
        e.name = name;
        e.val  = v;
        rd_q.push_back(e);
    endtask

    task automatic push_st(input string name, input int ch, input logic [7:0] a,
                           input logic rw, input logic [7:0] d);
        st_exp_t e;
        e.name = name;
        e.ch   = ch;
        e.addr = a;
        e.rw   = rw;
        e.din  = d;
        st_q.push_back(e);
    endtask

    // One CPU bus cycle; returns cycles with rdy low and io_sel at first sight.
    task automatic bus_cycle(input logic [7:0] b, input logic [15:0] a, input logic rw,
                             input logic [7:0] d, output int n_low, output logic s);
        @(negedge clk_sys);
        bus.bank = b; bus.addr = a; bus.cpu_rw = rw; bus.cpu_dout = d;
        bus.valid = 1'b1; bus.cen = 1'b1;
        #1;
        s = bus.io_sel;
        n_low = 0;
        while (!bus.rdy && n_low < 100) begin
            n_low++;
            @(negedge clk_sys);
            #1;
        end
        if (!bus.rdy) begin
            n_vec++; n_bad++;
            $display("FAIL rdy_bound: rdy still %0b after %0d cycles, expected 1", bus.rdy, n_low);
        end
        @(posedge clk_sys);
        @(negedge clk_sys);
        bus.valid = 1'b0;
    endtask

    // Read-data monitor: one expected entry per completed read cycle the DUT claims.
    initial begin
        forever begin
            @(negedge clk_sys);
            #2;
            if (!reset && bus.cen && bus.valid && bus.rdy && bus.io_sel && bus.cpu_rw) begin
                @(posedge clk_sys);
                #1;
                if (rd_q.size() == 0) begin
                    n_vec++; n_bad++;
                    $display("FAIL unexpected_read: io_dout %02h, no read expected", bus.io_dout);
                end else begin
                    rd_e = rd_q.pop_front();
                    check8(rd_e.name, bus.io_dout, rd_e.val);
                end
            end
        end
    end

    // Strobe monitor.
    initial begin
        forever begin
            @(negedge clk_sys);
            #2;
            if (per_strobe !== 2'b00) begin
                if (st_q.size() == 0) begin
                    n_vec++; n_bad++;
                    $display("FAIL unexpected_strobe: per_strobe %02b, expected none", per_strobe);
                end else begin
                    st_e = st_q.pop_front();
                    check8({st_e.name, "_strobe"}, {6'b0, per_strobe}, 8'(1 << st_e.ch));
                    check8({st_e.name, "_addr"}, per_addr, st_e.addr);
                    check8({st_e.name, "_rw"}, {7'b0, per_rw}, {7'b0, st_e.rw});
                    if (!st_e.rw) check8({st_e.name, "_din"}, per_din, st_e.din);
                end
            end
        end
    end

    // Peripheral responder: ack ack_dly cycles after the strobe, optionally a stray ack first.
    initial begin
        int ch;
        per_ack  = 2'b00;
        per_dout = 16'h0000;
        forever begin
            @(negedge clk_sys);
            #2;
            if (per_strobe !== 2'b00 && ack_dly >= 1) begin
                ch = per_strobe[1] ? 1 : 0;
                for (int k = 1; k <= ack_dly; k++) begin
                    @(negedge clk_sys);
                    per_ack = 2'b00;
                    if (stray && k == 1 && k < ack_dly) begin
                        per_ack[1-ch] = 1'b1;
                        per_dout[(1-ch)*8 +: 8] = 8'hEE;
                    end
                end
                per_ack[ch] = 1'b1;
                per_dout[ch*8 +: 8] = ack_data;
                @(negedge clk_sys);
                per_ack = 2'b00;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        bus.cen = 1'b0; bus.valid = 1'b0; bus.bank = 8'h00; bus.addr = 16'h0000;
        bus.cpu_rw = 1'b1; bus.cpu_dout = 8'h00;
        repeat (3) @(negedge clk_sys);
        reset = 1'b0;
        bus.cen = 1'b1;
        @(negedge clk_sys);
        #1;
        check8("rst_shadow", shadow, 8'h08);
        check8("rst_rdy", {7'b0, bus.rdy}, 8'h01);
        check8("rst_io_dout", bus.io_dout, 8'h00);
        check8("rst_timeout", {7'b0, timeout}, 8'h00);
        check8("rst_strobe", {6'b0, per_strobe}, 8'h00);

        push_rd("rd_c036", 8'h80);
        bus_cycle(8'h00, 16'hC036, 1'b1, 8'h00, low, sel);
        check8("rd_c036_low", 8'(low), 8'h00);

        bus_cycle(8'hE0, 16'hC068, 1'b0, 8'h8A, low, sel);
        push_rd("rd_c068", 8'h8B);
        bus_cycle(8'hE0, 16'hC068, 1'b1, 8'h00, low, sel);
        bus_cycle(8'h00, 16'hC034, 1'b0, 8'h5C, low, sel);
        check8("bordercolor", {4'h0, bordercolor}, 8'h0C);
        push_rd("rd_c034", 8'h5C);
        bus_cycle(8'h00, 16'hC034, 1'b1, 8'h00, low, sel);
        bus_cycle(8'hE1, 16'hC022, 1'b0, 8'h3F, low, sel);
        check8("textcolor", textcolor, 8'h3F);
        bus_cycle(8'h01, 16'hC02D, 1'b0, 8'h07, low, sel);
        check8("sltromsel", sltromsel, 8'h07);

        // cen held low: neither a register write nor a peripheral request may be taken.
        @(negedge clk_sys);
        bus.cen = 1'b0; bus.valid = 1'b1; bus.bank = 8'h00; bus.addr = 16'hC022;
        bus.cpu_rw = 1'b0; bus.cpu_dout = 8'h99;
        repeat (3) @(negedge clk_sys);
        bus.addr = 16'hC000; bus.cpu_rw = 1'b1;
        #1;
        check8("cen0_rdy_drop", {7'b0, bus.rdy}, 8'h00);
        repeat (3) @(negedge clk_sys);
        bus.valid = 1'b0; bus.cen = 1'b1;
        check8("cen0_textcolor", textcolor, 8'h3F);

        ack_dly = 3; ack_data = 8'hC1; stray = 1'b0;
        push_st("p0_rd", 0, 8'h00, 1'b1, 8'h00);
        push_rd("p0_rd_data", 8'hC1);
        bus_cycle(8'h00, 16'hC000, 1'b1, 8'h00, low, sel);
        check8("p0_rd_low", 8'(low), 8'd5);

        ack_dly = 1; ack_data = 8'h11;
        push_st("p0_wr", 0, 8'h10, 1'b0, 8'h5A);
        bus_cycle(8'h00, 16'hC010, 1'b0, 8'h5A, low, sel);
        check8("p0_wr_low", 8'(low), 8'd3);
        check8("p0_wr_io_dout", bus.io_dout, 8'hC1);

        ack_dly = 2; ack_data = 8'h77; stray = 1'b1;
        push_st("p0_stray", 0, 8'h24, 1'b1, 8'h00);
        push_rd("p0_stray_data", 8'h77);
        bus_cycle(8'h01, 16'hC024, 1'b1, 8'h00, low, sel);
        check8("p0_stray_low", 8'(low), 8'd4);
        stray = 1'b0;

        ack_dly = -1;
        push_st("p1_to", 1, 8'h33, 1'b1, 8'h00);
        push_rd("p1_to_data", 8'hFF);
        bus_cycle(8'h00, 16'hC033, 1'b1, 8'h00, low, sel);
        check8("p1_to_low", 8'(low), 8'd17);
        check8("timeout_set", {7'b0, timeout}, 8'h01);
        bus_cycle(8'h00, 16'hC0FF, 1'b0, 8'h00, low, sel);
        check8("timeout_clr", {7'b0, timeout}, 8'h00);

        // Reset in WAIT, with the peripheral acking well after the abort.
        ack_dly = 8; ack_data = 8'h5D;
        push_st("p0_rst", 0, 8'h25, 1'b1, 8'h00);
        @(negedge clk_sys);
        bus.bank = 8'hE1; bus.addr = 16'hC025; bus.cpu_rw = 1'b1; bus.valid = 1'b1; bus.cen = 1'b1;
        repeat (4) @(negedge clk_sys);
        reset = 1'b1; bus.valid = 1'b0;
        #1;
        check8("rst_wait_rdy", {7'b0, bus.rdy}, 8'h01);
        check8("rst_wait_strobe", {6'b0, per_strobe}, 8'h00);
        @(negedge clk_sys);
        reset = 1'b0;
        repeat (12) @(negedge clk_sys);
        #1;
        check8("late_ack_io_dout", bus.io_dout, 8'h00);
        check8("late_ack_rdy", {7'b0, bus.rdy}, 8'h01);
        check8("late_ack_timeout", {7'b0, timeout}, 8'h00);
        ack_dly = -1;

        bus_cycle(8'h02, 16'hC036, 1'b1, 8'h00, low, sel);
        check8("bank02_sel", {7'b0, sel}, 8'h00);
        bus_cycle(8'h00, 16'hC050, 1'b1, 8'h00, low, sel);
        check8("unmapped_sel", {7'b0, sel}, 8'h00);
        bus_cycle(8'h00, 16'hC035, 1'b0, 8'h40, low, sel);
        check8("shadow_40", shadow, 8'h40);
        bus_cycle(8'h00, 16'hC000, 1'b1, 8'h00, low, sel);
        check8("shadowed_sel", {7'b0, sel}, 8'h00);
        check8("shadowed_low", 8'(low), 8'h00);

        repeat (5) @(negedge clk_sys);
        check8("rd_queue_left", 8'(rd_q.size()), 8'h00);
        check8("st_queue_left", 8'(st_q.size()), 8'h00);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
